// File: rtl/mlaccel_pkg.sv
// Shared definitions for the QPI host: command opcodes and FSM state encoding.
package mlaccel_pkg;

    // Command opcodes carried on cmd_op; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        OP_START = 3'd0,
        OP_SEND  = 3'd1,
        OP_WAIT  = 3'd2,
        OP_RECV  = 3'd3,
        OP_POLL  = 3'd4,
        OP_STOP  = 3'd5
    } op_e;

    // Host FSM states; LO/HI name the QPI clock level of the half-phase.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_RSP  = 3'd3,
        ST_END  = 3'd4
    } state_e;

    // Commands that only make sense while the device is selected.
    function automatic logic op_needs_select(input op_e op);
        return (op == OP_SEND) || (op == OP_WAIT) ||
               (op == OP_RECV) || (op == OP_POLL);
    endfunction

endpackage

// File: rtl/mlaccel_qpi_tick.sv
// Half-phase timer: counts DIV-1 down to 0 and pulses tick on the final
// clock of every half-phase. Holding restart keeps it parked at DIV-1 so the
// next half-phase always starts with a full count.
module mlaccel_qpi_tick #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    // Down-counter with automatic reload at the end of each half-phase.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset || restart || (cnt == '0)) begin
            cnt <= CW'(DIV - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/mlaccel_qpi_host.sv
// QPI host controller: executes START/SEND/WAIT/RECV/POLL/STOP commands,
// generating csb/clk/io on registered pads and returning received bytes.
module mlaccel_qpi_host
    import mlaccel_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int NBYTES   = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [8*NBYTES-1:0]   cmd_data,
    input  logic [3:0]            cmd_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_data,
    output logic                  rsp_last,
    output logic                  err,
    output logic                  qpi_csb,
    output logic                  qpi_clk,
    output logic [3:0]            qpi_io_out,
    output logic                  qpi_io_oe,
    input  logic [3:0]            qpi_io_in
);

    localparam int BCW = $clog2(NBYTES + 1);
    localparam int PCW = $clog2(POLL_MAX + 1);

    state_e              state;
    op_e                 op;
    op_e                 cmd_op_e;
    logic                csb_sel;     // logical chip select, pads follow one clock later
    logic [8*NBYTES-1:0] shreg;       // SEND payload, byte 0 in the low bits
    logic [BCW-1:0]      bcnt;        // SEND bytes still to go, including current
    logic [PCW-1:0]      pcnt;        // POLL bytes received, saturating
    logic [3:0]          rx_hi;       // high nibble captured at the end of LO
    logic                second;      // second half-phase of WAIT-HI / END
    logic                tick;
    logic                restart;
    logic [7:0]          rx_byte;
    logic                poll_done;
    logic                poll_timeout;
    logic                send_active;
    logic [3:0]          tx_nibble;
    logic                bad_len;

    assign cmd_op_e     = op_e'(cmd_op);
    assign cmd_ready    = (state == ST_IDLE);
    assign rsp_valid    = (state == ST_RSP);
    assign restart      = (state == ST_IDLE) || (state == ST_RSP);
    assign rx_byte      = {rx_hi, qpi_io_in};
    assign poll_timeout = (pcnt == PCW'(POLL_MAX - 1));
    assign poll_done    = (rx_byte == 8'h00) || poll_timeout;
    assign bad_len      = (cmd_len == 4'd0) || (cmd_len > 4'(NBYTES));
    assign send_active  = (op == OP_SEND) && ((state == ST_LO) || (state == ST_HI));
    assign tx_nibble    = (state == ST_LO) ? shreg[7:4] : shreg[3:0];

    mlaccel_qpi_tick #(
        .DIV (DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Command sequencing FSM: state, payload/receive registers and err.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            op       <= OP_START;
            csb_sel  <= 1'b1;
            shreg    <= '0;
            bcnt     <= '0;
            pcnt     <= '0;
            rx_hi    <= '0;
            second   <= 1'b0;
            rsp_data <= '0;
            rsp_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op     <= cmd_op_e;
                        second <= 1'b0;
                        pcnt   <= '0;
                        if (op_needs_select(cmd_op_e) && csb_sel) begin
                            err <= 1'b1;
                        end else begin
                            case (cmd_op_e)
                                OP_START: begin
                                    csb_sel <= 1'b0;
                                    state   <= ST_HI;
                                end
                                OP_SEND: begin
                                    if (bad_len) begin
                                        err <= 1'b1;
                                    end else begin
                                        shreg <= cmd_data;
                                        bcnt  <= BCW'(cmd_len);
                                        state <= ST_LO;
                                    end
                                end
                                OP_WAIT, OP_RECV, OP_POLL, OP_STOP: state <= ST_LO;
                                default: err <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_LO: begin
                    if (tick) begin
                        rx_hi <= qpi_io_in;
                        if (op == OP_STOP) begin
                            csb_sel <= 1'b1;
                            state   <= ST_END;
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (tick) begin
                        case (op)
                            OP_SEND: begin
                                if (bcnt == BCW'(1)) begin
                                    state <= ST_IDLE;
                                end else begin
                                    bcnt  <= bcnt - 1'b1;
                                    shreg <= shreg >> 8;
                                    state <= ST_LO;
                                end
                            end
                            OP_WAIT: begin
                                if (!second) begin
                                    second <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                            OP_RECV, OP_POLL: begin
                                rsp_data <= rx_byte;
                                rsp_last <= (op == OP_POLL) && poll_done;
                                if ((op == OP_POLL) && (rx_byte != 8'h00) && poll_timeout) begin
                                    err <= 1'b1;
                                end
                                if (pcnt != PCW'(POLL_MAX)) begin
                                    pcnt <= pcnt + 1'b1;
                                end
                                state <= ST_RSP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_last <= 1'b0;
                        if ((op == OP_POLL) && !rsp_last) begin
                            state <= ST_LO;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_END: begin
                    if (tick) begin
                        if (!second) begin
                            second <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered pads, decoded from the state one clock after it changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            qpi_csb    <= 1'b1;
            qpi_clk    <= 1'b1;
            qpi_io_oe  <= 1'b0;
            qpi_io_out <= 4'h0;
        end else begin
            qpi_csb    <= csb_sel;
            qpi_clk    <= (state != ST_LO);
            qpi_io_oe  <= send_active;
            qpi_io_out <= send_active ? tx_nibble : 4'h0;
        end
    end

endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// Directed bench for mlaccel_qpi_host with a cycle-level pad model.
module tb_mlaccel_qpi_host;
    import mlaccel_pkg::*;

    localparam int DIV      = 4;
    localparam int NBYTES   = 4;
    localparam int POLL_MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        err;
    logic        qpi_csb;
    logic        qpi_clk;
    logic [3:0]  qpi_io_out;
    logic        qpi_io_oe;
    logic [3:0]  qpi_io_in;

    mlaccel_qpi_host #(
        .DIV      (DIV),
        .NBYTES   (NBYTES),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .err        (err),
        .qpi_csb    (qpi_csb),
        .qpi_clk    (qpi_clk),
        .qpi_io_out (qpi_io_out),
        .qpi_io_oe  (qpi_io_oe),
        .qpi_io_in  (qpi_io_in)
    );

    always #5 clock = ~clock;

    // Expected pad state for one sampled clock.
    typedef struct packed {
        logic       csb;
        logic       clk;
        logic       oe;
        logic [3:0] io;
    } pad_t;

    pad_t        exp_q[$];
    pad_t        cmp_e;
    logic        m_csb = 1'b1;
    logic        m_err = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  cur_byte = 8'h00;
    int          hi_cnt;
    logic        prev_clk = 1'b1;
    logic        prev_oe = 1'b0;
    logic [3:0]  nib_q[$];
    int          len_q[$];
    logic [7:0]  got_data[$];
    logic        got_last[$];

    // Slave model: high nibble while the pad clock is low, low nibble while high.
    assign qpi_io_in = qpi_clk ? cur_byte[3:0] : cur_byte[7:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic csb, input logic clk, input logic oe,
                        input logic [3:0] io, input int n);
        pad_t p;
        p = '{csb: csb, clk: clk, oe: oe, io: io};
        repeat (n) exp_q.push_back(p);
    endtask

    // One clock of idle-looking pads precedes every new segment.
    task automatic push_idle();
        push(m_csb, 1'b1, 1'b0, 4'h0, 1);
    endtask

    // Pad trace each command must produce, from its definition.
    task automatic model(input logic [2:0] op, input logic [31:0] data, input logic [3:0] len);
        logic [7:0] b;
        case (op)
            3'd0: begin
                push_idle();
                push(1'b0, 1'b1, 1'b0, 4'h0, DIV);
                m_csb = 1'b0;
            end
            3'd1: begin
                if (m_csb || len == 0 || len > NBYTES) begin
                    m_err = 1'b1;
                end else begin
                    push_idle();
                    for (int i = 0; i < int'(len); i++) begin
                        b = data[8*i +: 8];
                        push(1'b0, 1'b0, 1'b1, b[7:4], DIV);
                        push(1'b0, 1'b1, 1'b1, b[3:0], DIV);
                    end
                end
            end
            3'd2: begin
                if (m_csb) m_err = 1'b1;
                else begin
                    push_idle();
                    push(1'b0, 1'b0, 1'b0, 4'h0, DIV);
                    push(1'b0, 1'b1, 1'b0, 4'h0, 2*DIV);
                end
            end
            3'd3, 3'd4: begin
                if (m_csb) m_err = 1'b1;
                else begin
                    push_idle();
                    push(1'b0, 1'b0, 1'b0, 4'h0, DIV);
                    push(1'b0, 1'b1, 1'b0, 4'h0, DIV);
                end
            end
            3'd5: begin
                push_idle();
                push(m_csb, 1'b0, 1'b0, 4'h0, DIV);
                push(1'b1, 1'b1, 1'b0, 4'h0, 2*DIV);
                m_csb = 1'b1;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    // Compare process: pads and err against the model on every clock.
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
            else cmp_e = '{csb: m_csb, clk: 1'b1, oe: 1'b0, io: 4'h0};
            check("pads{csb,clk,oe,io}", 32'({qpi_csb, qpi_clk, qpi_io_oe, qpi_io_out}), 32'(cmp_e));
            check("err", 32'(err), 32'(m_err));
            if (qpi_io_oe) begin
                if (!prev_oe || (qpi_clk != prev_clk)) begin
                    nib_q.push_back(qpi_io_out);
                    len_q.push_back(1);
                end else begin
                    len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
                end
            end
            prev_clk = qpi_clk;
            prev_oe  = qpi_io_oe;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [3:0] len);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        model(op, data, len);
    endtask

    task automatic take_rsp(input logic [7:0] exp_data, input logic exp_last, input int hold,
                            input logic more, input logic [7:0] next_byte, input logic sets_err);
        int t = 0;
        while (!rsp_valid && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        if (sets_err) m_err = 1'b1;
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_last", 32'(rsp_last), 32'(exp_last));
        got_data.push_back(rsp_data);
        got_last.push_back(rsp_last);
        hi_cnt = 0;
        repeat (hold) begin
            @(posedge clock); #1;
            if (qpi_clk) hi_cnt++;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        if (more) begin
            cur_byte = next_byte;
            push_idle();
            push(1'b0, 1'b0, 1'b0, 4'h0, DIV);
            push(1'b0, 1'b1, 1'b0, 4'h0, DIV);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && t < 500) begin
            @(posedge clock); #1;
            t++;
        end
        check("drain_wait", 32'(t < 500), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        m_csb = 1'b1;
        m_err = 1'b0;
        check("rst_csb", 32'(qpi_csb), 32'd1);
        check("rst_clk", 32'(qpi_clk), 32'd1);
        check("rst_oe", 32'(qpi_io_oe), 32'd0);
        check("rst_io", 32'(qpi_io_out), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pol[3];
        logic [3:0] exp_nib[8];
        logic       last;
        int         extra;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
        cmd_len = 4'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        do_reset();

        // Commands before START: err, no pad activity.
        issue(3'd1, 32'h21, 4'd1);
        check("presel_err", 32'(err), 32'd1);
        check("presel_idle", 32'(cmd_ready), 32'd1);
        issue(3'd7, 32'h0, 4'd0);
        repeat (8) begin @(posedge clock); #1; end
        check("presel_no_nibbles", 32'(nib_q.size()), 32'd0);
        do_reset();

        // START, SEND 21, STOP.
        issue(3'd0, 32'h0, 4'd0);
        nib_q.delete(); len_q.delete();
        issue(3'd1, 32'h21, 4'd1);
        drain();
        check("s1_nib_count", 32'(nib_q.size()), 32'd2);
        if (nib_q.size() == 2) begin
            check("s1_nib0", 32'(nib_q[0]), 32'h2);
            check("s1_nib1", 32'(nib_q[1]), 32'h1);
            check("s1_len0", 32'(len_q[0]), 32'd4);
            check("s1_len1", 32'(len_q[1]), 32'd4);
        end
        issue(3'd5, 32'h0, 4'd0);
        drain();
        check("s1_csb_high", 32'(qpi_csb), 32'd1);

        // Four-byte SEND nibble order.
        issue(3'd0, 32'h0, 4'd0);
        nib_q.delete(); len_q.delete();
        issue(3'd1, 32'h00040001, 4'd4);
        drain();
        exp_nib = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
        check("s2_nib_count", 32'(nib_q.size()), 32'd8);
        if (nib_q.size() == 8) begin
            for (int i = 0; i < 8; i++) check("s2_nib", 32'(nib_q[i]), 32'(exp_nib[i]));
        end

        // WAIT then RECV with a stretched response.
        issue(3'd2, 32'h0, 4'd0);
        drain();
        cur_byte = 8'hA5;
        issue(3'd3, 32'h0, 4'd0);
        take_rsp(8'hA5, 1'b0, 10, 1'b0, 8'h00, 1'b0);
        check("recv_clk_held", 32'(hi_cnt), 32'd10);
        drain();

        // POLL terminating on 00.
        pol = '{8'h3F, 8'h12, 8'h00};
        got_data.delete(); got_last.delete();
        cur_byte = pol[0];
        issue(3'd4, 32'h0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            last = (pol[k] == 8'h00) || (k + 1 == POLL_MAX);
            take_rsp(pol[k], last, 0, !last, (k < 2) ? pol[(k < 2) ? k + 1 : 0] : 8'h00, 1'b0);
            if (last) break;
        end
        drain();
        check("poll_count", 32'(got_data.size()), 32'd3);
        if (got_last.size() == 3) begin
            check("poll_last0", 32'(got_last[0]), 32'd0);
            check("poll_last1", 32'(got_last[1]), 32'd0);
            check("poll_last2", 32'(got_last[2]), 32'd1);
            check("poll_data2", 32'(got_data[2]), 32'h00);
        end
        check("poll_err", 32'(err), 32'd0);
        issue(3'd5, 32'h0, 4'd0);
        drain();

        // POLL timeout on a device that never returns 00.
        issue(3'd0, 32'h0, 4'd0);
        got_data.delete(); got_last.delete();
        cur_byte = 8'hFF;
        issue(3'd4, 32'h0, 4'd0);
        for (int k = 0; k < POLL_MAX; k++) begin
            last = (k + 1 == POLL_MAX);
            take_rsp(8'hFF, last, 0, !last, 8'hFF, last);
        end
        extra = 0;
        repeat (3*DIV) begin
            @(posedge clock); #1;
            if (rsp_valid) extra++;
        end
        check("timeout_extra_rsp", 32'(extra), 32'd0);
        check("timeout_count", 32'(got_data.size()), 32'd4);
        if (got_last.size() == 4) check("timeout_last3", 32'(got_last[3]), 32'd1);
        check("timeout_err", 32'(err), 32'd1);

        // Illegal lengths send nothing; err stays set.
        nib_q.delete();
        issue(3'd1, 32'h55, 4'd0);
        issue(3'd1, 32'h55, 4'd5);
        repeat (4) begin @(posedge clock); #1; end
        check("badlen_no_nibbles", 32'(nib_q.size()), 32'd0);
        check("err_sticky", 32'(err), 32'd1);
        issue(3'd5, 32'h0, 4'd0);
        drain();

        // Reset during the HI half-phase of a SEND.
        issue(3'd0, 32'h0, 4'd0);
        drain();
        issue(3'd1, 32'h11223344, 4'd4);
        repeat (6) begin @(posedge clock); #1; end
        check("mid_hi_clk", 32'(qpi_clk), 32'd1);
        check("mid_hi_oe", 32'(qpi_io_oe), 32'd1);
        do_reset();
        repeat (4) begin @(posedge clock); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mlaccel_qpi_host.md
MLACCEL_QPI_HOST -- requirements
Module: mlaccel_qpi_host

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DIV, 4, system clocks per QPI half-phase; legal range 2..255.
- NBYTES, 4, maximum bytes per SEND command; legal range 1..8.
- POLL_MAX, 1024, maximum bytes received by one POLL before timeout.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clock, in, 1, system clock; the only clock in the block.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when high together with cmd_valid.
- cmd_op, in, 3, operation: 0 START, 1 SEND, 2 WAIT, 3 RECV, 4 POLL, 5 STOP; 6 and 7 reserved.
- cmd_data, in, 8*NBYTES, SEND payload; byte 0 is bits [7:0] and is sent first.
- cmd_len, in, 4, SEND byte count, 1..NBYTES.
- rsp_valid, out, 1, received byte available.
- rsp_ready, in, 1, received byte consumed.
- rsp_data, out, 8, received byte.
- rsp_last, out, 1, marks the final byte of a POLL.
- err, out, 1, sticky error flag.
- qpi_csb, out, 1, chip select, active low.
- qpi_clk, out, 1, QPI clock; idles high.
- qpi_io_out, out, 4, data lanes driven to the pads.
- qpi_io_oe, out, 1, lane output enable.
- qpi_io_in, in, 4, data lanes sampled from the pads.

Function
REQ-003 SHALL accept exactly one command per cmd_valid&cmd_ready cycle; cmd_ready SHALL be high only in IDLE.
REQ-004 SHALL implement states IDLE, LO (qpi_clk=0), HI (qpi_clk=1), RSP (holding rsp_valid) and END (STOP tail), each timed by a half-phase counter counting DIV-1 down to 0.
REQ-005 START SHALL drive qpi_csb=0 and qpi_clk=1, spend one HI half-phase, then return to IDLE.
REQ-006 SEND SHALL transmit one byte per LO+HI pair, cmd_len bytes in total:
- during LO: io_out = byte[7:4], oe=1;
- during HI: io_out = byte[3:0], oe=1.
REQ-007 WAIT SHALL run one LO half-phase then two HI half-phases, with oe=0.
REQ-008 RECV SHALL run one LO+HI pair with oe=0:
- qpi_io_in is sampled on the last clock of LO into bits [7:4] and on the last clock of HI into bits [3:0];
- the assembled byte is then presented in RSP.
REQ-009 In RSP, rsp_valid SHALL stay high and qpi_clk SHALL hold high until rsp_ready is high, which stretches the QPI clock.
REQ-010 POLL SHALL repeat RECV until a received byte equals 8'h00; every byte, including the final 00, SHALL be emitted, and the 00 SHALL carry rsp_last=1.
REQ-011 POLL SHALL stop after POLL_MAX bytes without a 00:
- the last byte is emitted with rsp_last=1;
- err is set.
REQ-012 STOP SHALL run one LO half-phase, then drive csb=1, clk=1 and oe=0 for two half-phases (END), then return to IDLE.
REQ-013 SEND, WAIT, RECV and POLL issued while csb=1 SHALL NOT toggle any pad, SHALL set err, and SHALL return to IDLE within 1 clock; reserved opcodes behave the same.
REQ-014 A cmd_len of 0 or greater than NBYTES SHALL set err and send nothing.
REQ-015 err SHALL be sticky and cleared only by reset.
REQ-016 All pad outputs SHALL be registered, so a pad changes 1 clock after the state change that causes it.
REQ-017 The byte counter SHALL be $clog2(NBYTES+1) bits wide; the poll counter SHALL be $clog2(POLL_MAX+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-018 On reset, and also when reset is asserted mid-transfer, outputs SHALL take these values on the next clock:
- state = IDLE;
- qpi_csb=1, qpi_clk=1, qpi_io_oe=0, qpi_io_out=0;
- cmd_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, err=0;
- any partially transferred byte is discarded.

Structure
REQ-019 The opcode enumeration and state encoding SHALL live in the shared package mlaccel_pkg.
REQ-020 The half-phase timer SHALL be a separate sub-module, mlaccel_qpi_tick, parametrised by DIV; it outputs a one-clock pulse at the end of each half-phase and is restartable.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DIV=4: START, then SEND of 8'h21 with cmd_len=1, then STOP -> pad trace shows csb low; clk low 4 clocks with io=2, high 4 clocks with io=1; then clk low 4 clocks; csb high.
- NBYTES=4: SEND of 32'h00040001 with cmd_len=4 -> nibbles on io in order 0,1,0,0,0,4,0,0.
- RECV with the model driving byte A5 and rsp_ready held low for 10 clocks -> rsp_data=A5 and qpi_clk held high during those 10 clocks.
- POLL with the model returning 3F, 12, 00 -> three responses, rsp_last=1 only on the 00, err=0.
- POLL_MAX=4 with the model returning FF forever -> exactly 4 responses, rsp_last on the 4th, err=1.
- Reset asserted in the middle of a SEND HI phase -> next clock csb=1, clk=1, oe=0, cmd_ready=1; also SEND issued before START -> err=1 with no pad activity.
